// File: rtl/univ_reg_counter_pkg.sv
// Shared encodings and elaboration helpers for the universal register/counter.
package univ_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_UP   = 3'd4,
    MODE_DOWN = 3'd5,
    MODE_TGL  = 3'd6,
    MODE_ROTL = 3'd7
  } mode_e;

  // A modulus of 0 stands for the full 2**width range.
  function automatic longint unsigned eff_mod(input int width, input longint unsigned modulus);
    return (modulus == 64'd0) ? (64'd1 << width) : modulus;
  endfunction

endpackage

// File: rtl/univ_reg_counter_if.sv
// Control/data bundle between a sequencer and one universal register/counter.
interface univ_reg_counter_if #(parameter int WIDTH = 8);
  import univ_reg_pkg::*;

  logic             pre;
  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qp;
  logic             ser_out;
  logic             tc;
  logic             wrap;

  modport master (
    output pre, en, mode, d, ser_in,
    input  q, qp, ser_out, tc, wrap
  );

  modport slave (
    input  pre, en, mode, d, ser_in,
    output q, qp, ser_out, tc, wrap
  );

endinterface

// File: rtl/univ_reg_counter_next.sv
// Combinational next-state, wrap and terminal-count logic; holds no state.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  mode_e            mode,
  input  logic             en,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap_next,
  output logic             tc
);

  localparam longint unsigned M_EFF    = eff_mod(WIDTH, MODULUS);
  localparam longint unsigned M_LAST_L = M_EFF - 64'd1;
  localparam logic [WIDTH-1:0] M_LAST  = M_LAST_L[WIDTH-1:0];

  logic out_of_range;
  assign out_of_range = ({{(64-WIDTH){1'b0}}, q} >= M_EFF);

  always_comb begin
    next_q    = q;
    wrap_next = 1'b0;
    tc        = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: next_q = q;
        MODE_LOAD: next_q = d;
        MODE_SHL:  next_q = {q[WIDTH-2:0], ser_in};
        MODE_SHR:  next_q = {ser_in, q[WIDTH-1:1]};
        MODE_UP: begin
          tc = (q == M_LAST);
          // Out-of-range values fold back to zero as if they had just wrapped.
          if (q >= M_LAST) begin
            next_q    = '0;
            wrap_next = 1'b1;
          end else begin
            next_q = q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          tc = (q == '0);
          if (q == '0) begin
            next_q    = M_LAST;
            wrap_next = 1'b1;
          end else if (out_of_range) begin
            next_q = M_LAST;
          end else begin
            next_q = q - WIDTH'(1);
          end
        end
        MODE_TGL:  next_q = q ^ d;
        MODE_ROTL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
        default:   next_q = q;
      endcase
    end
  end

endmodule

// File: rtl/univ_reg_counter.sv
// Universal register/counter: q/wrap registers with clr/pre priority over the next-state logic.
module univ_reg_counter
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter longint unsigned  MODULUS    = 0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input logic                clock,
  input logic                clr,
  univ_reg_counter_if.slave  bus
);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_q;
  logic             wrap_next;
  logic             tc;

  univ_reg_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q         (q_r),
    .d         (bus.d),
    .ser_in    (bus.ser_in),
    .mode      (bus.mode),
    .en        (bus.en),
    .next_q    (next_q),
    .wrap_next (wrap_next),
    .tc        (tc)
  );

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else if (bus.pre) begin
      q_r    <= PRESET_VAL;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= next_q;
      wrap_r <= wrap_next;
    end
  end

  assign bus.q       = q_r;
  assign bus.qp      = ~q_r;
  assign bus.ser_out = (bus.mode == MODE_SHL) ? q_r[WIDTH-1] : q_r[0];
  assign bus.tc      = tc;
  assign bus.wrap    = wrap_r;

endmodule

// File: tb/tb_univ_reg_counter.sv
// Bench for two univ_reg_counter configurations (4-bit mod-10, 8-bit full range) against an arithmetic model.
module tb_univ_reg_counter;
  import univ_reg_pkg::*;

  logic clock = 1'b0;
  logic clr   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  longint eq4 = 0, eq8 = 0;
  bit     ew4 = 0, ew8 = 0;

  univ_reg_counter_if #(.WIDTH(4)) bus4 ();
  univ_reg_counter_if #(.WIDTH(8)) bus8 ();

  univ_reg_counter #(.WIDTH(4), .MODULUS(10)) dut4 (.clock(clock), .clr(clr), .bus(bus4.slave));
  univ_reg_counter #(.WIDTH(8), .MODULUS(0))  dut8 (.clock(clock), .clr(clr), .bus(bus8.slave));

  always #5 clock = ~clock;

  // Reference behaviour from plain integer arithmetic on the register value.
  task automatic ref_step(input int w, input longint m, input longint q, input bit pre, input bit en,
                          input int mode, input longint d, input bit ser,
                          output longint nq, output bit nw);
    longint full;
    full = longint'(1) << w;
    nw   = 1'b0;
    if (pre) nq = full - 1;
    else if (!en) nq = q;
    else begin
      case (mode)
        1: nq = d;
        2: nq = (q * 2 + longint'(ser)) % full;
        3: nq = longint'(ser) * (full / 2) + q / 2;
        4: if (q >= m - 1) begin nq = 0; nw = 1'b1; end else nq = q + 1;
        5: if (q == 0) begin nq = m - 1; nw = 1'b1; end
           else if (q >= m) nq = m - 1;
           else nq = q - 1;
        6: nq = q ^ d;
        7: nq = (q * 2) % full + q / (full / 2);
        default: nq = q;
      endcase
    end
  endtask

  function automatic bit tc_ref(input longint m, input longint q, input bit en, input int mode);
    return en && ((mode == 4 && q == m - 1) || (mode == 5 && q == 0));
  endfunction

  function automatic bit ser_ref(input int w, input longint q, input int mode);
    return (mode == 2) ? bit'((q >> (w - 1)) & 1) : bit'(q & 1);
  endfunction

  task automatic tick();
    longint n4, n8;
    bit     w4, w8;
    ref_step(4, 10,  eq4, bus4.pre, bus4.en, int'(bus4.mode), longint'(bus4.d), bus4.ser_in, n4, w4);
    ref_step(8, 256, eq8, bus8.pre, bus8.en, int'(bus8.mode), longint'(bus8.d), bus8.ser_in, n8, w8);
    @(posedge clock);
    if (clr) begin n4 = 0; n8 = 0; w4 = 0; w8 = 0; end
    eq4 = n4; eq8 = n8; ew4 = w4; ew8 = w8;
    #1;
  endtask

  task automatic idle_all();
    bus4.pre = 0; bus4.en = 0; bus4.mode = MODE_HOLD; bus4.d = '0; bus4.ser_in = 0;
    bus8.pre = 0; bus8.en = 0; bus8.mode = MODE_HOLD; bus8.d = '0; bus8.ser_in = 0;
  endtask

  task automatic test_reset();
    idle_all();
    clr = 1'b1;
    #12;
    checks++;
    if (bus8.q !== 8'h00 || bus8.qp !== 8'hFF || bus8.wrap !== 1'b0) begin
      errors++; $display("FAIL reset8 q=%h qp=%h wrap=%b exp 00 FF 0", bus8.q, bus8.qp, bus8.wrap);
    end
    checks++;
    if (bus4.q !== 4'h0 || bus4.qp !== 4'hF || bus4.wrap !== 1'b0) begin
      errors++; $display("FAIL reset4 q=%h qp=%h wrap=%b exp 0 F 0", bus4.q, bus4.qp, bus4.wrap);
    end
    clr = 1'b0; eq4 = 0; eq8 = 0; ew4 = 0; ew8 = 0;
    bus8.en = 1; bus8.mode = MODE_LOAD; bus8.d = 8'h5A;
    tick();
    checks++;
    if (bus8.q !== 8'h5A) begin errors++; $display("FAIL load5a q=%h exp 5a", bus8.q); end
    #2 clr = 1'b1; eq8 = 0; eq4 = 0; ew4 = 0; ew8 = 0;
    #1;
    checks++;
    if (bus8.q !== 8'h00 || bus8.qp !== 8'hFF) begin
      errors++; $display("FAIL async_clr q=%h qp=%h exp 00 FF", bus8.q, bus8.qp);
    end
    bus8.mode = MODE_UP;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus8.q !== 8'h00) begin errors++; $display("FAIL clr_hold%0d q=%h exp 00", i, bus8.q); end
    end
    idle_all();
    @(negedge clock) clr = 1'b0;
  endtask

  task automatic test_up_mod10();
    bus4.en = 1; bus4.mode = MODE_UP;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus4.tc !== (i == 9)) begin errors++; $display("FAIL up_tc q=%h tc=%b exp %b", bus4.q, bus4.tc, i == 9); end
      tick();
      checks++;
      if (bus4.q !== 4'((i + 1) % 10) || bus4.wrap !== (i == 9)) begin
        errors++; $display("FAIL up_seq step%0d q=%h wrap=%b exp %h %b", i, bus4.q, bus4.wrap, (i + 1) % 10, i == 9);
      end
    end
    tick();
    checks++;
    if (bus4.q !== 4'h1 || bus4.wrap !== 1'b0) begin
      errors++; $display("FAIL up_wrap_width q=%h wrap=%b exp 1 0", bus4.q, bus4.wrap);
    end
    idle_all();
  endtask

  task automatic test_down();
    bus4.en = 1; bus4.mode = MODE_LOAD; bus4.d = 4'hC;
    tick();
    checks++;
    if (bus4.q !== 4'hC) begin errors++; $display("FAIL load_oor q=%h exp c", bus4.q); end
    bus4.mode = MODE_DOWN;
    tick();
    checks++;
    if (bus4.q !== 4'h9 || bus4.wrap !== 1'b0) begin
      errors++; $display("FAIL down_oor q=%h wrap=%b exp 9 0", bus4.q, bus4.wrap);
    end
    bus4.mode = MODE_LOAD; bus4.d = 4'h0;
    tick();
    bus4.mode = MODE_DOWN;
    #1;
    checks++;
    if (bus4.tc !== 1'b1) begin errors++; $display("FAIL down_tc tc=%b exp 1", bus4.tc); end
    tick();
    checks++;
    if (bus4.q !== 4'h9 || bus4.wrap !== 1'b1) begin
      errors++; $display("FAIL down_wrap q=%h wrap=%b exp 9 1", bus4.q, bus4.wrap);
    end
    idle_all();
  endtask

  task automatic test_shift_rotate();
    bus8.en = 1; bus8.mode = MODE_LOAD; bus8.d = 8'h81;
    tick();
    bus8.mode = MODE_SHL; bus8.ser_in = 0;
    #1;
    checks++;
    if (bus8.ser_out !== 1'b1) begin errors++; $display("FAIL shl_serout_pre got %b exp 1", bus8.ser_out); end
    tick();
    checks++;
    if (bus8.q !== 8'h02 || bus8.ser_out !== 1'b0) begin
      errors++; $display("FAIL shl q=%h ser_out=%b exp 02 0", bus8.q, bus8.ser_out);
    end
    bus8.mode = MODE_SHR; bus8.ser_in = 1;
    tick();
    checks++;
    if (bus8.q !== 8'h81) begin errors++; $display("FAIL shr q=%h exp 81", bus8.q); end
    bus8.mode = MODE_ROTL;
    tick();
    checks++;
    if (bus8.q !== 8'h03) begin errors++; $display("FAIL rotl q=%h exp 03", bus8.q); end
    idle_all();
  endtask

  task automatic test_toggle_priority();
    bus8.en = 1; bus8.mode = MODE_LOAD; bus8.d = 8'hF0;
    tick();
    bus8.mode = MODE_TGL; bus8.d = 8'h3C;
    tick();
    checks++;
    if (bus8.q !== 8'hCC) begin errors++; $display("FAIL toggle q=%h exp cc", bus8.q); end
    bus8.pre = 1;
    tick();
    checks++;
    if (bus8.q !== 8'hFF || bus8.wrap !== 1'b0) begin
      errors++; $display("FAIL preset q=%h wrap=%b exp ff 0", bus8.q, bus8.wrap);
    end
    clr = 1'b1; eq4 = 0; eq8 = 0; ew4 = 0; ew8 = 0;
    tick();
    checks++;
    if (bus8.q !== 8'h00) begin errors++; $display("FAIL pre_and_clr q=%h exp 00", bus8.q); end
    bus8.pre = 0; bus8.en = 0; bus8.mode = MODE_DOWN; bus8.d = 8'h55;
    @(negedge clock) clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus8.tc !== 1'b0) begin errors++; $display("FAIL en0_tc cycle%0d tc=%b exp 0", i, bus8.tc); end
      tick();
      checks++;
      if (bus8.q !== 8'h00 || bus8.wrap !== 1'b0) begin
        errors++; $display("FAIL en0_hold cycle%0d q=%h wrap=%b exp 00 0", i, bus8.q, bus8.wrap);
      end
    end
    idle_all();
  endtask

  task automatic test_full_wrap();
    bus8.en = 1; bus8.mode = MODE_LOAD; bus8.d = 8'hFF;
    tick();
    bus8.mode = MODE_UP;
    #1;
    checks++;
    if (bus8.tc !== 1'b1) begin errors++; $display("FAIL full_tc tc=%b exp 1", bus8.tc); end
    tick();
    checks++;
    if (bus8.q !== 8'h00 || bus8.wrap !== 1'b1) begin
      errors++; $display("FAIL full_wrap q=%h wrap=%b exp 00 1", bus8.q, bus8.wrap);
    end
    idle_all();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus4.pre = ($urandom_range(0, 19) == 0); bus4.en = ($urandom_range(0, 9) != 0);
      bus4.mode = mode_e'(3'($urandom_range(0, 7))); bus4.d = 4'($urandom); bus4.ser_in = 1'($urandom);
      bus8.pre = ($urandom_range(0, 19) == 0); bus8.en = ($urandom_range(0, 9) != 0);
      bus8.mode = mode_e'(3'($urandom_range(0, 7))); bus8.d = 8'($urandom); bus8.ser_in = 1'($urandom);
      #1;
      checks++;
      if (bus4.tc !== tc_ref(10, eq4, bus4.en, int'(bus4.mode)) || bus4.qp !== 4'(15 - eq4)
          || bus4.ser_out !== ser_ref(4, eq4, int'(bus4.mode))) begin
        errors++; $display("FAIL rnd4_comb i=%0d tc=%b qp=%h so=%b model_q=%h", i, bus4.tc, bus4.qp, bus4.ser_out, eq4);
      end
      checks++;
      if (bus8.tc !== tc_ref(256, eq8, bus8.en, int'(bus8.mode)) || bus8.qp !== 8'(255 - eq8)
          || bus8.ser_out !== ser_ref(8, eq8, int'(bus8.mode))) begin
        errors++; $display("FAIL rnd8_comb i=%0d tc=%b qp=%h so=%b model_q=%h", i, bus8.tc, bus8.qp, bus8.ser_out, eq8);
      end
      tick();
      checks++;
      if (bus4.q !== 4'(eq4) || bus4.wrap !== ew4) begin
        errors++; $display("FAIL rnd4_state i=%0d q=%h wrap=%b exp %h %b", i, bus4.q, bus4.wrap, eq4, ew4);
      end
      checks++;
      if (bus8.q !== 8'(eq8) || bus8.wrap !== ew8) begin
        errors++; $display("FAIL rnd8_state i=%0d q=%h wrap=%b exp %h %b", i, bus8.q, bus8.wrap, eq8, ew8);
      end
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_up_mod10();
    test_down();
    test_shift_rotate();
    test_toggle_priority();
    test_full_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
